// File: rtl/sm83_regbank.sv
// sm83_regbank: two-bank SM83 register-pair file with read ports, write port and increment/decrement unit
module sm83_regbank #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_PAIRS = 6,
  parameter int NUM_BANKED = 4,
  parameter int MASK_PAIR = 3,
  parameter logic [WORD_SIZE-1:0] MASK_LO = 'hf0,
  parameter bit BYPASS = 1'b0,
  localparam int SW = $clog2(NUM_PAIRS),
  localparam int PW = 2 * WORD_SIZE
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [SW-1:0] rd_a_sel_i,
  output logic [PW-1:0] rd_a_o,
  input  logic [SW-1:0] rd_b_sel_i,
  output logic [PW-1:0] rd_b_o,
  input  logic [SW-1:0] wr_sel_i,
  input  logic          wr_hi_we_i,
  input  logic          wr_lo_we_i,
  input  logic [PW-1:0] wr_data_i,
  input  logic [SW-1:0] inc_sel_i,
  input  logic          inc_en_i,
  input  logic          inc_dec_i,
  output logic [PW-1:0] inc_out_o,
  input  logic          bank_swap_i,
  output logic          bank_o,
  output logic          collide_o
);
  localparam logic [SW:0] NP = (SW+1)'(NUM_PAIRS);
  localparam logic [SW:0] NB = (SW+1)'(NUM_BANKED);
  localparam logic [SW:0] MP = (SW+1)'(MASK_PAIR);
  localparam int N = 2 ** (SW + 1);
  logic [PW-1:0] regs_q [N];
  logic [PW-1:0] regs_d [N];
  logic          bank_q, collide_q;
  logic          wr_v, inc_v, clash;
  logic [PW-1:0] wmask, inc_base;
  // Storage slot {bank, pair}; shared pairs always live in bank 0.
  function automatic logic [SW:0] addr(input logic [SW-1:0] s, input logic b);
    return {b && ({1'b0, s} < NB), s};
  endfunction
  // Bits that exist for a pair: none for out-of-range selects, masked low half for the flags pair.
  function automatic logic [PW-1:0] mask(input logic [SW-1:0] s);
    return ({1'b0, s} >= NP) ? '0 : ({1'b0, s} == MP) ? {{WORD_SIZE{1'b1}}, MASK_LO} : '1;
  endfunction
  // Read value with optional forwarding of the halves selected by bm.
  function automatic logic [PW-1:0] rd(input logic [SW-1:0] s, input logic [PW-1:0] v,
                                       input logic [PW-1:0] bm, input logic [PW-1:0] wd);
    return ((v & ~bm) | (wd & bm)) & mask(s);
  endfunction
  assign wmask = {{WORD_SIZE{wr_hi_we_i}}, {WORD_SIZE{wr_lo_we_i}}};
  assign rd_a_o = rd(rd_a_sel_i, regs_q[addr(rd_a_sel_i, bank_q)],
                     (BYPASS && rd_a_sel_i == wr_sel_i) ? wmask : '0, wr_data_i);
  assign rd_b_o = rd(rd_b_sel_i, regs_q[addr(rd_b_sel_i, bank_q)],
                     (BYPASS && rd_b_sel_i == wr_sel_i) ? wmask : '0, wr_data_i);
  assign inc_base = regs_q[addr(inc_sel_i, bank_q)] & mask(inc_sel_i);
  assign inc_out_o = inc_base + (inc_dec_i ? '1 : PW'(1));
  assign bank_o = bank_q;
  assign collide_o = collide_q;
  // Next-state: the write owns its pair on a conflict and the increment is dropped.
  always_comb begin
    regs_d = regs_q;
    wr_v = (wr_hi_we_i || wr_lo_we_i) && ({1'b0, wr_sel_i} < NP);
    inc_v = inc_en_i && ({1'b0, inc_sel_i} < NP);
    clash = wr_v && inc_v && wr_sel_i == inc_sel_i;
    if (inc_v && !clash) regs_d[addr(inc_sel_i, bank_q)] = inc_out_o & mask(inc_sel_i);
    if (wr_v) regs_d[addr(wr_sel_i, bank_q)] = rd(wr_sel_i, regs_q[addr(wr_sel_i, bank_q)], wmask, wr_data_i);
  end
  // State update; reset clears everything immediately and beats any same-cycle activity.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      regs_q <= '{default: '0};
      bank_q <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      bank_q <= bank_q ^ bank_swap_i;
      collide_q <= clash;
    end
  end
endmodule

// File: doc/sm83_regbank.md
SM83_REGBANK -- requirements
Module: sm83_regbank

Interface
REQ-001 Parameter WORD_SIZE, default 8: width of one register half; a pair is 2*WORD_SIZE bits.
REQ-002 Parameter NUM_PAIRS, default 6: number of register pairs (0 BC, 1 DE, 2 HL, 3 AF, 4 SP, 5 PC).
REQ-003 Parameter NUM_BANKED, default 4: pairs with index < NUM_BANKED exist in two banks; the remaining pairs are shared.
REQ-004 Parameter MASK_PAIR, default 3, and MASK_LO, default 'hf0: the low half of pair MASK_PAIR is stored and read ANDed with MASK_LO.
REQ-005 Parameter BYPASS, default 0: when 1, read ports forward same-cycle write data.
REQ-006 Let SW = clog2(NUM_PAIRS) and PW = 2*WORD_SIZE.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 rd_a_sel  in  SW  pair select, read port A.
REQ-010 rd_a  out  PW  read port A data, combinational.
REQ-011 rd_b_sel  in  SW  pair select, read port B.
REQ-012 rd_b  out  PW  read port B data, combinational.
REQ-013 wr_sel  in  SW  write pair select.
REQ-014 wr_hi_we, wr_lo_we  in  1 each  write enables for the high and low halves.
REQ-015 wr_data  in  PW  write data.
REQ-016 inc_sel  in  SW  increment/decrement pair select.
REQ-017 inc_en  in  1  performs the increment/decrement this cycle.
REQ-018 inc_dec  in  1  0 = +1, 1 = -1.
REQ-019 inc_out  out  PW  combinational result of pair[inc_sel] ±1, for address use.
REQ-020 bank_swap  in  1  toggles the active bank.
REQ-021 bank  out  1  active bank, registered.
REQ-022 collide  out  1  registered pulse flagging a write/increment conflict.

Function
REQ-023 Reads: rd_x = stored value of the selected pair in the active bank, with the masked low half for MASK_PAIR; a select >= NUM_PAIRS reads 0.
REQ-024 Write: at the edge, each enabled half of pair[wr_sel] in the active bank takes the matching half of wr_data (low half masked for MASK_PAIR); the disabled half is unchanged.
REQ-025 Increment: when inc_en is set, pair[inc_sel] <= pair ±1 modulo 2^PW; 'hffff+1 -> 0000 and 0000-1 -> 'hffff; the carry crosses between halves.
REQ-026 inc_out equals the value that REQ-025 would write, independent of inc_en.
REQ-027 Conflict: if a write half-enable and inc_en hit the same pair in the same cycle, the write wins on written halves, the increment is discarded entirely, and collide = 1 for exactly the next cycle.
REQ-028 Write and increment to different pairs in the same cycle both take effect.
REQ-029 Bank swap: bank toggles at the edge; a write, increment or read in the same cycle uses the pre-swap bank; shared pairs are unaffected by the bank.
REQ-030 BYPASS=1: a read matching wr_sel returns wr_data on enabled halves and stored data on the others. BYPASS=0: reads return pre-edge values.
REQ-031 Writes or increments with a select >= NUM_PAIRS are ignored and raise no collide.
REQ-032 Latency: written data is visible on read ports one cycle after the write edge (zero cycles with BYPASS=1).

Reset
REQ-033 While reset is high, all pairs in both banks = 0, bank = 0 and collide = 0, taking effect asynchronously.
REQ-034 Reset asserted mid-operation overrides any same-cycle write, increment or swap.
REQ-035 inc_out reflects reset values during reset (0001 or ffff per inc_dec).

Verification
REQ-036 Write pair 3 = 'h12ff with both enables, then read -> rd_a = 'h12f0; write pair 0 low only = 'h55 -> pair 0 = 'h0055.
REQ-037 Pair 5 = 'hffff, inc_en, inc_dec=0 -> pair 5 = 'h0000; next inc_dec=1 -> 'hffff; inc_out tracks each step.
REQ-038 Write pair 2 = 'hAAAA, then bank_swap + write pair 2 = 'h1111 in the same cycle -> bank 1 reads pair 2 = 0; swap back -> reads 'h1111; pair 4 is the same in both banks.
REQ-039 Same cycle: write pair 1 high ('h77xx) + inc pair 1 from 'h00ff -> pair 1 = 'h77ff, collide = 1 for one cycle, then 0.
REQ-040 BYPASS=1: write pair 0 = 'hBEEF while rd_b_sel = 0 -> rd_b = 'hBEEF in the same cycle; BYPASS=0 -> old value.
REQ-041 Load nonzero values, pulse reset between clock edges -> all reads 0, bank = 0 immediately; a same-cycle write is lost.
